cpu_run_ctrl: RTL

Run/halt sequencer in front of the CPU status block. It turns host debug commands (run, step N cycles, stop, set breakpoint) into the single-cycle cpu_start / quit_cmd pulses consumed by cpu_status. It counts executed cycles, watches the IF-stage PC for a breakpoint, and holds off new commands until the pipeline-reset wave has drained. It sits between the UART command decoder and cpu_status.

---
 rtl/cpu_run_pkg.sv | 30 +++
 rtl/cpu_run_ctrl_if.sv | 14 +
 rtl/cpu_bp_match.sv | 54 +++++
 rtl/cpu_run_ctrl.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/cpu_run_pkg.sv
// Shared encodings for the run/halt sequencer: host command opcodes,
// halt causes and the sequencer FSM states.
package cpu_run_pkg;

  typedef enum logic [1:0] {
    OP_RUN   = 2'd0,
    OP_STEP  = 2'd1,
    OP_STOP  = 2'd2,
    OP_SETBP = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_HOST = 2'd1,
    CAUSE_STEP = 2'd2,
    CAUSE_BP   = 2'd3
  } halt_cause_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_RUN   = 3'd2,
    ST_STEP  = 3'd3,
    ST_QUIT  = 3'd4,
    ST_DRAIN = 3'd5
  } state_e;

  localparam int CMD_DATA_W = 32;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Host command channel (valid/ready) from the UART command decoder
// into the run/halt sequencer.
interface cpu_run_ctrl_if;
  import cpu_run_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [CMD_DATA_W-1:0] cmd_data;

  modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);

endinterface

// File: rtl/cpu_bp_match.sv
// Breakpoint register and PC comparator. The first running cycle after a
// start is masked so execution can resume from the breakpoint address.
module cpu_bp_match #(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            set_en,
  input  logic [PC_W-1:0] set_data,
  input  logic            start,
  input  logic            active,
  input  logic            stall,
  input  logic [PC_W-1:0] pc_if,
  output logic            hit
);

  logic            bp_en_q, bp_en_d;
  logic [PC_W-1:1] bp_addr_q, bp_addr_d;
  logic            first_q, first_d;
  logic            unused_pc_lsb;

  // PCs are halfword aligned at minimum, so bit 0 carries the enable instead.
  assign unused_pc_lsb = pc_if[0];

  always_comb begin
    bp_en_d   = bp_en_q;
    bp_addr_d = bp_addr_q;
    first_d   = first_q;
    if (set_en) begin
      bp_en_d   = set_data[0];
      bp_addr_d = set_data[PC_W-1:1];
    end
    if (start) begin
      first_d = 1'b1;
    end else if (active) begin
      first_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bp_en_q   <= 1'b0;
      bp_addr_q <= '0;
      first_q   <= 1'b0;
    end else begin
      bp_en_q   <= bp_en_d;
      bp_addr_q <= bp_addr_d;
      first_q   <= first_d;
    end
  end

  assign hit = bp_en_q & active & ~first_q & ~stall & (pc_if[PC_W-1:1] == bp_addr_q);

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt sequencer: turns host debug commands into cpu_start / quit_cmd pulses.
// Breakpoint support is built only when CPU_RUN_CTRL_BREAKPOINT_EN is defined.
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int STEP_W    = 16,
  parameter int DRAIN_CYC = 6,
  parameter int PC_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  cpu_run_ctrl_if.slave     cmd,
  input  logic              stall,
  input  logic [PC_W-1:0]   pc_if,
  output logic              cpu_start,
  output logic              quit_cmd,
  output logic              running,
  output logic [1:0]        halt_cause,
  output logic [PC_W-1:0]   halt_pc,
  output logic [STEP_W-1:0] cyc_cnt
);

  localparam int DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  state_e              state_q, state_d;
  logic [DRAIN_W-1:0]  drain_q, drain_d;
  logic [STEP_W-1:0]   target_q, target_d;
  logic                mode_step_q, mode_step_d;
  logic [STEP_W-1:0]   cyc_q, cyc_d;
  halt_cause_e         cause_q, cause_d;
  logic [PC_W-1:0]     halt_pc_q, halt_pc_d;

  cmd_op_e             op;
  logic                accept;
  logic                bp_hit;
  logic                step_done;
  logic [STEP_W-1:0]   step_count;

  assign op         = cmd_op_e'(cmd.cmd_op);
  assign step_count = cmd.cmd_data[STEP_W-1:0];
  assign cmd.cmd_ready = (state_q == ST_IDLE) || (state_q == ST_RUN) || (state_q == ST_STEP);
  assign accept     = cmd.cmd_valid & cmd.cmd_ready;
  assign running    = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign cpu_start  = (state_q == ST_START);
  assign quit_cmd   = (state_q == ST_QUIT);

  // Extra bit keeps the compare honest when cyc_q sits at all-ones.
  assign step_done = (state_q == ST_STEP) && !stall &&
                     (({1'b0, cyc_q} + 1'b1) == {1'b0, target_q});

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
  cpu_bp_match #(.PC_W(PC_W)) u_bp_match (
    .clk      (clk),
    .rst      (rst),
    .set_en   (accept && (op == OP_SETBP)),
    .set_data (cmd.cmd_data[PC_W-1:0]),
    .start    (cpu_start),
    .active   (running),
    .stall    (stall),
    .pc_if    (pc_if),
    .hit      (bp_hit)
  );
`else
  logic unused_cmd_bits;
  assign unused_cmd_bits = ^cmd.cmd_data[CMD_DATA_W-1:STEP_W];
  assign bp_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    target_d    = target_q;
    mode_step_d = mode_step_q;
    cyc_d       = cyc_q;
    cause_d     = cause_q;
    halt_pc_d   = halt_pc_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (op == OP_RUN) begin
            mode_step_d = 1'b0;
            state_d     = ST_START;
          end else if (op == OP_STEP && step_count != '0) begin
            mode_step_d = 1'b1;
            target_d    = step_count;
            state_d     = ST_START;
          end
        end
      end
      ST_START: begin
        cyc_d   = '0;
        cause_d = CAUSE_NONE;
        state_d = mode_step_q ? ST_STEP : ST_RUN;
      end
      ST_RUN, ST_STEP: begin
        if (!stall && cyc_q != '1) begin
          cyc_d = cyc_q + 1'b1;
        end
        // Host stop outranks breakpoint, which outranks step completion.
        if (accept && op == OP_STOP) begin
          cause_d = CAUSE_HOST;
          state_d = ST_QUIT;
        end else if (bp_hit) begin
          cause_d = CAUSE_BP;
          state_d = ST_QUIT;
        end else if (step_done) begin
          cause_d = CAUSE_STEP;
          state_d = ST_QUIT;
        end
      end
      ST_QUIT: begin
        halt_pc_d = pc_if;
        drain_d   = DRAIN_W'(DRAIN_CYC - 1);
        state_d   = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      drain_q     <= '0;
      target_q    <= '0;
      mode_step_q <= 1'b0;
      cyc_q       <= '0;
      cause_q     <= CAUSE_NONE;
      halt_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      target_q    <= target_d;
      mode_step_q <= mode_step_d;
      cyc_q       <= cyc_d;
      cause_q     <= cause_d;
      halt_pc_q   <= halt_pc_d;
    end
  end

  assign halt_cause = cause_q;
  assign halt_pc    = halt_pc_q;
  assign cyc_cnt    = cyc_q;

endmodule
